crc_stream_engine: RTL
======================

# crc_stream_engine

Parametrised, clocked CRC engine that accumulates a CRC over a stream of DATA_W-bit words, one word per cycle, under a valid/ready handshake. It generalises the fixed 16-bit combinational CRC update to any CRC width, polynomial, init/final-XOR value and input word width. It also frames messages and holds the result until the consumer takes it. It sits between the fingerprint data source and the packet/verification logic, and provides both CRC generation and zero-residue checking.

## Interface

- CRC_W, 16: CRC register width (8..32).
- DATA_W, 16: input word width; multiple of 8, 8..64.
- POLY, 16'h1021: generator polynomial, MSB-first, implicit x^CRC_W term.
- INIT, 16'hFFFF: register value loaded at frame start.
- XOROUT, 16'h0000: value XORed onto the register to form out_crc.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse that loads INIT and begins a frame; aborts any frame in progress.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  engine accepts a word this cycle.
- in_data  in  DATA_W  message word; bit DATA_W-1 is processed first.
- in_last  in  1  the current word is the final word of the frame.
- out_valid  out  1  result held on out_crc/out_zero/out_count.
- out_ready  in  1  consumer takes the result.
- out_crc  out  CRC_W  final CRC = register ^ XOROUT.
- out_zero  out  1  raw register (before XOROUT) == 0; this is the residue check.
- out_count  out  16  number of words accepted in the frame; saturates at 16'hFFFF.

## Operation

- State machine: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1.
  - An accepted word (in_valid & in_ready) with no start implicitly starts a frame from INIT.
  - A word with in_last=0 goes to ACCUM; a word with in_last=1 goes to HOLD.
- ACCUM:
  - in_ready=1.
  - Each accepted word sets reg <= step(reg, in_data) and increments count.
  - An accepted word with in_last=1 goes to HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - Outputs are held stable until out_ready=1; then go to IDLE.
- step(): DATA_W serial iterations, MSB first, computed combinationally within one cycle:
  - fb = reg[CRC_W-1] ^ d[i]
  - reg = (reg << 1) ^ (fb ? POLY : 0)
- start handling:
  - start in any state sets reg=INIT and count=0.
  - If a word is accepted in the same cycle, that word is the first word of the new frame: reg=step(INIT, in_data) and count=1.
  - start in HOLD discards the pending result and moves to ACCUM, or to HOLD if the same-cycle word has in_last=1.
- The register persists across IDLE. A word accepted in IDLE without start restarts from INIT; there is no chaining across frames.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.

## Timing

- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_crc=INIT^XOROUT, out_zero=(INIT==0), out_count=0.
- Throughput: one word per cycle within a frame.
- Latency: out_valid rises on the cycle after the in_last word is accepted.
- Frame gap: at least one cycle, because in_ready is low while in HOLD.
- Back-to-back frames:
  - out_ready high on the first HOLD cycle gives IDLE the next cycle.
  - in_ready=1 in that same IDLE cycle.
- out_crc, out_zero and out_count are registered, with no combinational path from inputs.
- in_ready depends only on state, not combinationally on out_ready.
- Reset asserted mid-frame: outputs go to their reset values asynchronously, and the partial frame is lost.
- count saturates at 16'hFFFF and does not wrap.

## Test plan

- Check value, CCITT-FALSE:
  - Parameters: DATA_W=8, POLY=1021, INIT=FFFF, XOROUT=0.
  - Stimulus: bytes "123456789" (0x31..0x39), last on 0x39.
  - Required response: out_crc=0x29B1, out_count=9, out_zero=0.
- XMODEM variant, 16-bit words:
  - Parameters: DATA_W=16, INIT=0000.
  - Stimulus: words 0x3132, 0x3334, 0x3536, 0x3738, then DATA_W=8 for byte 0x39. Alternatively, run the full 8-bit sequence.
  - Required response: out_crc=0x31C3.
- Residue check:
  - Stimulus: "123456789" followed by 0x29, 0xB1 (CCITT-FALSE).
  - Required response: out_zero=1, out_crc=0x0000, out_count=11.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after the result.
  - Required response: out_valid and outputs stable, in_ready=0 throughout.
  - Then pulse out_ready: next cycle state=IDLE and in_ready=1.
- Abort and restart:
  - Stimulus: start plus word 0x31 in the same cycle in the middle of the frame "1234", followed by "23456789".
  - Required response: out_crc=0x29B1, out_count=9.
- Async reset:
  - Stimulus: assert reset between clock edges during ACCUM.
  - Required response: out_valid=0 and in_ready=1 immediately.
  - The next frame "123456789" gives 0x29B1.

Source files
------------

// File: rtl/crc_stream_engine_if.sv
// Stream bus for crc_stream_engine: word input with framing plus the held CRC result.
// The master side feeds words and takes results; the slave side is the engine.
interface crc_stream_engine_if #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 16
) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CRC_W-1:0]  out_crc;
    logic              out_zero;
    logic [15:0]       out_count;

    modport master (
        output start, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_crc, out_zero, out_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_crc, out_zero, out_count
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Parametrised MSB-first CRC over a framed word stream, one word per cycle.
// The result is held in HOLD until the consumer takes it; out_zero is the residue check.
module crc_stream_engine #(
    parameter int               CRC_W  = 16,
    parameter int               DATA_W = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_stream_engine_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [15:0]      count_q, count_d;
    logic             accept;
    logic             fresh;

    // Whole word folded in one cycle: DATA_W unrolled shift/XOR steps.
    function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] r,
                                              input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = r;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_crc   = crc_q ^ XOROUT;
    assign bus.out_zero  = (crc_q == '0);
    assign bus.out_count = count_q;

    assign accept = bus.in_valid && bus.in_ready;
    // A word taken in IDLE or alongside start opens a new frame from INIT.
    assign fresh  = bus.start || (state == IDLE);

    always_comb begin
        state_d = state;
        crc_d   = crc_q;
        count_d = count_q;
        if (bus.start) begin
            crc_d   = INIT;
            count_d = '0;
            state_d = ACCUM;
        end
        if (accept) begin
            crc_d   = step(fresh ? INIT : crc_q, bus.in_data);
            count_d = fresh ? 16'd1 :
                      (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d = bus.in_last ? HOLD : ACCUM;
        end else if (state == HOLD && bus.out_ready && !bus.start) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            crc_q   <= INIT;
            count_q <= '0;
        end else begin
            state   <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
        end
    end
endmodule
